// File: rtl/merge_pkg.sv
// Shared types and sizing helpers for the merge-sort datapath stages.
package merge_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int RUN_LEN_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        MERGE,
        DRAIN_A,
        DRAIN_B,
        DONE
    } merge_state_t;

    // Element counters must hold the value RUN_LEN itself, hence the extra bit.
    function automatic int cnt_w(input int run_len);
        return $clog2(run_len) + 1;
    endfunction

endpackage

// File: rtl/merge_stage_if.sv
// Handshake bundle for one merge stage: two upstream run FIFOs and one merged output.
interface merge_stage_if #(
    parameter int DATA_W = merge_pkg::DATA_W_DEF
) ();

    logic              a_valid;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_src;
    logic              out_last;
    logic              out_ready;

    modport master (
        output a_valid, a_data, b_valid, b_data, out_ready,
        input  a_ready, b_ready, out_valid, out_data, out_src, out_last
    );

    modport slave (
        input  a_valid, a_data, b_valid, b_data, out_ready,
        output a_ready, b_ready, out_valid, out_data, out_src, out_last
    );

endinterface

// File: rtl/merge_compare.sv
// Pure-combinational ordering decision between two elements; ties always favour A.
module merge_compare #(
    parameter int DATA_W = 16,
    parameter bit SIGNED = 1'b0
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              descend,
    output logic              take_a
);

    logic a_lt_b;

    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        if (SIGNED) begin
            a_lt_b = $signed(a) < $signed(b);
        end else begin
            a_lt_b = a < b;
        end
        // Ascending takes a <= b, descending takes a >= b; equality lands on A either way.
        take_a = (a == b) || (descend ? !a_lt_b : a_lt_b);
    end

endmodule

// File: rtl/merge_stage.sv
// Two-way merge of sorted runs A and B into one run of 2*RUN_LEN elements,
// with a one-entry registered output slot and a saturating busy-cycle counter.
module merge_stage
    import merge_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RUN_LEN = RUN_LEN_DEF,
    parameter bit SIGNED  = 1'b0,
    parameter int CYC_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             descend,
    merge_stage_if.slave     io,
    output logic             busy,
    output logic             done,
    output logic [CYC_W-1:0] cycles
);

    localparam int               CNT_W   = cnt_w(RUN_LEN);
    localparam logic [CNT_W-1:0] RUN_CNT = CNT_W'(RUN_LEN);
    localparam logic [CNT_W:0]   TOTAL   = (CNT_W + 1)'(2 * RUN_LEN);

    merge_state_t      state_q, state_d;
    logic [CNT_W-1:0]  cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0]  cnt_b_q, cnt_b_d;
    logic              desc_q, desc_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_src_q, out_src_d;
    logic              out_last_q, out_last_d;
    logic [CYC_W-1:0]  cycles_q, cycles_d;

    logic             take_a;
    logic             load;
    logic             pop_a;
    logic             pop_b;
    logic [CNT_W:0]   total_next;

    merge_compare #(
        .DATA_W (DATA_W),
        .SIGNED (SIGNED)
    ) u_compare (
        .a       (io.a_data),
        .b       (io.b_data),
        .descend (desc_q),
        .take_a  (take_a)
    );

    // Pops double as the upstream ready strobes, so they must stay low in reset.
    always_comb begin
        load  = !out_valid_q || io.out_ready;
        pop_a = 1'b0;
        pop_b = 1'b0;
        if (reset) begin
            case (state_q)
                MERGE: begin
                    pop_a = load && io.a_valid && io.b_valid && take_a;
                    pop_b = load && io.a_valid && io.b_valid && !take_a;
                end
                DRAIN_A: pop_a = load && io.a_valid && (cnt_a_q != RUN_CNT);
                DRAIN_B: pop_b = load && io.b_valid && (cnt_b_q != RUN_CNT);
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_a_d     = cnt_a_q;
        cnt_b_d     = cnt_b_q;
        desc_d      = desc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_last_d  = out_last_q;
        cycles_d    = cycles_q;
        total_next  = {1'b0, cnt_a_q} + {1'b0, cnt_b_q} + (CNT_W + 1)'(1);

        if (pop_a) cnt_a_d = cnt_a_q + CNT_W'(1);
        if (pop_b) cnt_b_d = cnt_b_q + CNT_W'(1);

        if (pop_a || pop_b) begin
            out_valid_d = 1'b1;
            out_data_d  = pop_a ? io.a_data : io.b_data;
            out_src_d   = pop_b;
            out_last_d  = (total_next == TOTAL);
        end else if (io.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (busy && (cycles_q != '1)) cycles_d = cycles_q + CYC_W'(1);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    desc_d   = descend;
                    cnt_a_d  = '0;
                    cnt_b_d  = '0;
                    cycles_d = '0;
                    state_d  = MERGE;
                end
            end
            MERGE: begin
                if (pop_a && (cnt_a_d == RUN_CNT)) begin
                    state_d = DRAIN_B;
                end else if (pop_b && (cnt_b_d == RUN_CNT)) begin
                    state_d = DRAIN_A;
                end
            end
            DRAIN_A, DRAIN_B: begin
                // Finish only once the final element has left the output slot.
                if ((cnt_a_q == RUN_CNT) && (cnt_b_q == RUN_CNT) && load) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: reset is sampled on the clock edge here, and all state uses non-blocking assignments.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_a_q     <= '0;
            cnt_b_q     <= '0;
            desc_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
            out_last_q  <= 1'b0;
            cycles_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_a_q     <= cnt_a_d;
            cnt_b_q     <= cnt_b_d;
            desc_q      <= desc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_last_q  <= out_last_d;
            cycles_q    <= cycles_d;
        end
    end

    assign busy         = (state_q == MERGE) || (state_q == DRAIN_A) || (state_q == DRAIN_B);
    assign done         = (state_q == DONE);
    assign cycles       = cycles_q;
    assign io.a_ready   = pop_a;
    assign io.b_ready   = pop_b;
    assign io.out_valid = out_valid_q;
    assign io.out_data  = out_data_q;
    assign io.out_src   = out_src_q;
    assign io.out_last  = out_last_q;

endmodule

// File: tb/tb_merge_stage.sv
// Scoreboard bench: a RUN_LEN=4 unsigned stage for most scenarios and a RUN_LEN=2 signed stage.
module tb_merge_stage;

    typedef struct packed {
        logic [15:0] data;
        logic        src;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, descend, busy, done;
    logic [15:0] cycles;
    logic        s_start, s_descend, s_busy, s_done;
    logic [15:0] s_cycles;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    logic [15:0] a_run[4];
    logic [15:0] b_run[4];
    logic [15:0] exp_d[8];
    logic [7:0]  exp_s;

    merge_stage_if #(.DATA_W(16)) mif ();
    merge_stage_if #(.DATA_W(16)) sif ();

    merge_stage #(.DATA_W(16), .RUN_LEN(4), .SIGNED(1'b0), .CYC_W(16)) dut (
        .clock(clk), .reset(rst_n), .start(start), .descend(descend),
        .io(mif), .busy(busy), .done(done), .cycles(cycles)
    );

    merge_stage #(.DATA_W(16), .RUN_LEN(2), .SIGNED(1'b1), .CYC_W(16)) dut_s (
        .clock(clk), .reset(rst_n), .start(s_start), .descend(s_descend),
        .io(sif), .busy(s_busy), .done(s_done), .cycles(s_cycles)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push_all();
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.data = exp_d[i];
            e.src  = exp_s[i];
            e.last = (i == 7);
            sb.push_back(e);
        end
    endtask

    // Runs one merge on the RUN_LEN=4 stage; exp_cycles < 0 means "stalled, must exceed 9".
    task automatic run_merge(input string name, input logic desc, input bit stall, input bit poke,
                             input int abort_after, input int exp_cycles);
        int   ai = 0, bi = 0, n_out = 0, busy_cnt = 0;
        bit   finished = 0, held = 0;
        exp_t held_v, e;
        @(negedge clk);
        start = 1'b1; descend = desc;
        mif.a_valid = 1'b0; mif.b_valid = 1'b0; mif.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            mif.a_valid   = (ai < 4);
            mif.a_data    = a_run[(ai < 4) ? ai : 3];
            mif.b_valid   = (bi < 4) && !(stall && c >= 5 && c <= 7);
            mif.b_data    = b_run[(bi < 4) ? bi : 3];
            mif.out_ready = stall ? (c % 2 == 0) : 1'b1;
            if (poke) begin
                start   = (c == 3);
                descend = (c == 3) ? !desc : desc;
            end
            #1;
            if (done) begin
                finished = 1;
                break;
            end
            if (busy) busy_cnt++;
            if (held) begin
                checks++;
                if (!mif.out_valid || {mif.out_data, mif.out_src, mif.out_last} !== held_v) begin
                    errors++;
                    $display("FAIL %s stall_hold c=%0d: got v=%b %h/%b/%b required v=1 %h/%b/%b",
                             name, c, mif.out_valid, mif.out_data, mif.out_src, mif.out_last,
                             held_v.data, held_v.src, held_v.last);
                end
            end
            held   = mif.out_valid && !mif.out_ready;
            held_v = {mif.out_data, mif.out_src, mif.out_last};
            if (mif.out_valid && mif.out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra_out: got %h with no element expected", name, mif.out_data);
                end else begin
                    e = sb.pop_front();
                    if ({mif.out_data, mif.out_src, mif.out_last} !== e) begin
                        errors++;
                        $display("FAIL %s out[%0d]: got %h/src%b/last%b required %h/src%b/last%b",
                                 name, n_out, mif.out_data, mif.out_src, mif.out_last,
                                 e.data, e.src, e.last);
                    end
                end
                n_out++;
            end
            if (mif.a_valid && mif.a_ready) ai++;
            if (mif.b_valid && mif.b_ready) bi++;
            if (abort_after != 0 && n_out == abort_after) break;
            @(negedge clk);
        end
        start = 1'b0; descend = desc;
        mif.a_valid = 1'b0; mif.b_valid = 1'b0;
        if (abort_after != 0) return;
        checks++;
        if (!finished || sb.size() != 0 || n_out != 8) begin
            errors++;
            $display("FAIL %s completion: got done=%b outputs=%0d left=%0d required done=1 outputs=8 left=0",
                     name, finished, n_out, sb.size());
            sb.delete();
        end
        checks++;
        if (cycles !== 16'(busy_cnt)) begin
            errors++;
            $display("FAIL %s cycles_vs_bench: got %0d required %0d", name, cycles, busy_cnt);
        end
        checks++;
        if ((exp_cycles >= 0) ? (cycles !== 16'(exp_cycles)) : !(cycles > 16'd9)) begin
            errors++;
            $display("FAIL %s cycles: got %0d required %0d (negative = above 9)", name, cycles, exp_cycles);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; descend = 1'b0; s_start = 1'b0; s_descend = 1'b0;
        mif.a_valid = 1'b1; mif.b_valid = 1'b1; mif.a_data = 16'd1; mif.b_data = 16'd2;
        mif.out_ready = 1'b1;
        sif.a_valid = 1'b0; sif.b_valid = 1'b0; sif.a_data = '0; sif.b_data = '0; sif.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (mif.a_ready !== 1'b0 || mif.b_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got a=%b b=%b required 0 0", mif.a_ready, mif.b_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({mif.out_valid, mif.out_last, done, busy, cycles, mif.a_ready} !== '0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b last=%b done=%b busy=%b cycles=%0d a_ready=%b required all 0",
                     mif.out_valid, mif.out_last, done, busy, cycles, mif.a_ready);
        end
        mif.a_valid = 1'b0; mif.b_valid = 1'b0;
    endtask

    task automatic test_basic();
        a_run = '{16'd1, 16'd3, 16'd5, 16'd7};
        b_run = '{16'd2, 16'd4, 16'd6, 16'd8};
        exp_d = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
        exp_s = 8'b1010_1010;
        push_all();
        run_merge("basic", 1'b0, 1'b0, 1'b0, 0, 9);
    endtask

    task automatic test_ties();
        a_run = '{16'd2, 16'd2, 16'd5, 16'd9};
        b_run = '{16'd2, 16'd3, 16'd3, 16'd9};
        exp_d = '{16'd2, 16'd2, 16'd2, 16'd3, 16'd3, 16'd5, 16'd9, 16'd9};
        exp_s = 8'b1001_1100;
        push_all();
        run_merge("ties", 1'b0, 1'b0, 1'b0, 0, 9);
    endtask

    task automatic test_drain();
        a_run = '{16'd1, 16'd2, 16'd3, 16'd4};
        b_run = '{16'd10, 16'd11, 16'd12, 16'd13};
        exp_d = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd10, 16'd11, 16'd12, 16'd13};
        exp_s = 8'b1111_0000;
        push_all();
        run_merge("drain", 1'b0, 1'b0, 1'b0, 0, 9);
    endtask

    task automatic test_descend();
        a_run = '{16'd9, 16'd7, 16'd3, 16'd1};
        b_run = '{16'd8, 16'd6, 16'd2, 16'd0};
        exp_d = '{16'd9, 16'd8, 16'd7, 16'd6, 16'd3, 16'd2, 16'd1, 16'd0};
        exp_s = 8'b1010_1010;
        push_all();
        run_merge("descend", 1'b1, 1'b0, 1'b0, 0, 9);
    endtask

    task automatic test_backpressure();
        a_run = '{16'd1, 16'd3, 16'd5, 16'd7};
        b_run = '{16'd2, 16'd4, 16'd6, 16'd8};
        exp_d = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
        exp_s = 8'b1010_1010;
        push_all();
        run_merge("backpressure", 1'b0, 1'b1, 1'b0, 0, -1);
    endtask

    task automatic test_reset_mid();
        a_run = '{16'd1, 16'd3, 16'd5, 16'd7};
        b_run = '{16'd2, 16'd4, 16'd6, 16'd8};
        exp_d = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
        exp_s = 8'b1010_1010;
        push_all();
        run_merge("reset_mid", 1'b0, 1'b0, 1'b0, 3, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b0; mif.a_valid = 1'b1; mif.b_valid = 1'b1;
        #1;
        checks++;
        if (mif.a_ready !== 1'b0 || mif.b_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_ready: got a=%b b=%b required 0 0", mif.a_ready, mif.b_ready);
        end
        @(negedge clk);
        rst_n = 1'b1; mif.a_valid = 1'b0; mif.b_valid = 1'b0;
        #1;
        checks++;
        if ({mif.out_valid, done, busy, cycles} !== '0) begin
            errors++;
            $display("FAIL reset_mid_state: got valid=%b done=%b busy=%b cycles=%0d required 0 0 0 0",
                     mif.out_valid, done, busy, cycles);
        end
        a_run = '{16'd4, 16'd8, 16'd12, 16'd16};
        b_run = '{16'd5, 16'd6, 16'd7, 16'd20};
        exp_d = '{16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd12, 16'd16, 16'd20};
        exp_s = 8'b1000_1110;
        push_all();
        run_merge("restart_poke", 1'b0, 1'b0, 1'b1, 0, 9);
    endtask

    task automatic test_signed();
        logic [15:0] sa[2];
        logic [15:0] sbv[2];
        exp_t        e;
        int          ai = 0, bi = 0, n_out = 0, bc = 0;
        bit          finished = 0;
        sa  = '{16'hFFFD, 16'd4};
        sbv = '{16'hFFFB, 16'd6};
        e = '{data: 16'hFFFB, src: 1'b1, last: 1'b0}; sb.push_back(e);
        e = '{data: 16'hFFFD, src: 1'b0, last: 1'b0}; sb.push_back(e);
        e = '{data: 16'd4,    src: 1'b0, last: 1'b0}; sb.push_back(e);
        e = '{data: 16'd6,    src: 1'b1, last: 1'b1}; sb.push_back(e);
        @(negedge clk);
        s_start = 1'b1; s_descend = 1'b0;
        @(negedge clk);
        s_start = 1'b0;
        for (int c = 0; c < 50; c++) begin
            sif.a_valid = (ai < 2);
            sif.a_data  = sa[(ai < 2) ? ai : 1];
            sif.b_valid = (bi < 2);
            sif.b_data  = sbv[(bi < 2) ? bi : 1];
            #1;
            if (s_done) begin
                finished = 1;
                break;
            end
            if (s_busy) bc++;
            if (sif.out_valid) begin
                checks++;
                e = (sb.size() != 0) ? sb.pop_front() : '0;
                if ({sif.out_data, sif.out_src, sif.out_last} !== e) begin
                    errors++;
                    $display("FAIL signed out[%0d]: got %h/src%b/last%b required %h/src%b/last%b",
                             n_out, sif.out_data, sif.out_src, sif.out_last, e.data, e.src, e.last);
                end
                n_out++;
            end
            if (sif.a_valid && sif.a_ready) ai++;
            if (sif.b_valid && sif.b_ready) bi++;
            @(negedge clk);
        end
        sif.a_valid = 1'b0; sif.b_valid = 1'b0;
        checks++;
        if (!finished || n_out != 4 || s_cycles !== 16'd5 || s_cycles !== 16'(bc)) begin
            errors++;
            $display("FAIL signed completion: got done=%b outputs=%0d cycles=%0d bench=%0d required 1 4 5 5",
                     finished, n_out, s_cycles, bc);
        end
        sb.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ties();
        test_drain();
        test_descend();
        test_signed();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
